// File: rtl/mem_port_ctrl_if.sv
// Bus bundle between the memory port controller and its neighbours:
// the UART byte stream, the fetch and draw read requesters, and the memory.
interface mem_port_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic [7:0]            rx_i;
    logic                  rx_i_v;
    logic                  reload;
    logic                  load_done;

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  fetch_rvalid;

    logic                  draw_req;
    logic [ADDR_WIDTH-1:0] draw_addr;
    logic                  draw_gnt;
    logic                  draw_rvalid;

    logic [DATA_WIDTH-1:0] rdata;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_d;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0] mem_q;

    modport slave (
        input  rx_i, rx_i_v, reload,
        input  fetch_req, fetch_addr, draw_req, draw_addr, mem_q,
        output load_done, fetch_gnt, fetch_rvalid, draw_gnt, draw_rvalid, rdata,
        output mem_we, mem_waddr, mem_d, mem_raddr
    );

    modport master (
        output rx_i, rx_i_v, reload,
        output fetch_req, fetch_addr, draw_req, draw_addr, mem_q,
        input  load_done, fetch_gnt, fetch_rvalid, draw_gnt, draw_rvalid, rdata,
        input  mem_we, mem_waddr, mem_d, mem_raddr
    );
endinterface

// File: rtl/mem_port_ctrl.sv
// Loads a program image from the UART stream into memory, then shares the
// single read port between instruction fetch and the draw engine round-robin.
module mem_port_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 12'h200,
    parameter int                    LOAD_LEN   = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_port_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(LOAD_LEN + 1);

    typedef enum logic [1:0] {ST_LOAD, ST_DONE, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_last_draw;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [DATA_WIDTH-1:0] r_mem_d;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic                  r_fetch_rvalid;
    logic                  r_draw_rvalid;

    logic                  w_run;
    logic                  w_capture;
    logic                  w_last_byte;
    logic                  w_fetch_gnt;
    logic                  w_draw_gnt;
    logic [ADDR_WIDTH-1:0] w_load_addr;
    logic [ADDR_WIDTH-1:0] w_raddr;

    assign w_run       = (r_state == ST_RUN);
    assign w_capture   = (r_state == ST_LOAD) && bus.rx_i_v && !bus.reload;
    assign w_last_byte = (r_cnt == CNT_W'(LOAD_LEN - 1));
    assign w_load_addr = LOAD_BASE + ADDR_WIDTH'(r_cnt);

    // NOTE: default assigned first so every path drives w_next_state and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: if (bus.rx_i_v && w_last_byte) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_RUN;
            ST_RUN:  w_next_state = ST_RUN;
            default: w_next_state = ST_LOAD;
        endcase
        if (bus.reload) w_next_state = ST_LOAD;
    end

    // On a tie the requester that did not win last time is granted.
    assign w_fetch_gnt = w_run && bus.fetch_req && (!bus.draw_req || r_last_draw);
    assign w_draw_gnt  = w_run && bus.draw_req && (!bus.fetch_req || !r_last_draw);
    assign w_raddr     = w_fetch_gnt ? bus.fetch_addr :
                         (w_draw_gnt ? bus.draw_addr : r_raddr);

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_LOAD;
            r_cnt          <= '0;
            r_last_draw    <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_waddr    <= '0;
            r_mem_d        <= '0;
            r_raddr        <= '0;
            r_fetch_rvalid <= 1'b0;
            r_draw_rvalid  <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_mem_we       <= w_capture;
            r_raddr        <= w_raddr;
            r_fetch_rvalid <= w_fetch_gnt;
            r_draw_rvalid  <= w_draw_gnt;
            if (w_fetch_gnt || w_draw_gnt) r_last_draw <= w_draw_gnt;
            if (bus.reload) begin
                r_cnt <= '0;
            end else if (w_capture) begin
                r_cnt       <= r_cnt + CNT_W'(1);
                r_mem_waddr <= w_load_addr;
                r_mem_d     <= DATA_WIDTH'(bus.rx_i);
            end
        end
    end

    assign bus.load_done    = w_run;
    assign bus.fetch_gnt    = w_fetch_gnt;
    assign bus.draw_gnt     = w_draw_gnt;
    assign bus.fetch_rvalid = r_fetch_rvalid;
    assign bus.draw_rvalid  = r_draw_rvalid;
    assign bus.rdata        = bus.mem_q;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_waddr    = r_mem_waddr;
    assign bus.mem_d        = r_mem_d;
    assign bus.mem_raddr    = w_raddr;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench: a default instance for loading/arbitration/reload/reset
// and a small wrapping-base instance for the gapped, wrapping load.
module tb_mem_port_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [7:0] mem     [4096];
    logic [7:0] exp_mem [4096];

    mem_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) a_if ();
    mem_port_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) b_if ();

    mem_port_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(12), .LOAD_BASE(12'h200), .LOAD_LEN(256)
    ) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    mem_port_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(12), .LOAD_BASE(12'hFFE), .LOAD_LEN(4)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous memory: read data appears the cycle after the address.
    always @(posedge clk) begin
        if (a_if.mem_we) mem[a_if.mem_waddr] <= a_if.mem_d;
        a_if.mem_q <= mem[a_if.mem_raddr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog expired");
    end

    // Loads 256 bytes into instance A, checking every write and the done timing.
    task automatic load_image(input bit incr, input int max_gap);
        int          sent   = 0;
        int          gap    = 0;
        bit          prev_v = 1'b0;
        logic [11:0] prev_a = '0;
        logic [7:0]  prev_d = '0;
        logic [7:0]  byte_v;
        while (1) begin
            @(negedge clk);
            n_cmp++;
            if (a_if.mem_we !== prev_v ||
                (prev_v && (a_if.mem_waddr !== prev_a || a_if.mem_d !== prev_d))) begin
                n_err++;
                $display("FAIL load_write: got we=%b addr=%h d=%h, want we=%b addr=%h d=%h",
                         a_if.mem_we, a_if.mem_waddr, a_if.mem_d, prev_v, prev_a, prev_d);
            end
            n_cmp++;
            if (a_if.fetch_gnt !== 1'b0 || a_if.draw_gnt !== 1'b0 || a_if.load_done !== 1'b0) begin
                n_err++;
                $display("FAIL load_quiet: got fgnt=%b dgnt=%b done=%b, want 0 0 0",
                         a_if.fetch_gnt, a_if.draw_gnt, a_if.load_done);
            end
            a_if.rx_i_v = 1'b0;
            if (sent == 256) break;
            if (gap > 0) begin
                gap--;
                prev_v = 1'b0;
            end else begin
                byte_v       = incr ? 8'(sent) : 8'($urandom);
                a_if.rx_i    = byte_v;
                a_if.rx_i_v  = 1'b1;
                prev_v       = 1'b1;
                prev_a       = 12'h200 + 12'(sent);
                prev_d       = byte_v;
                exp_mem[prev_a] = byte_v;
                sent++;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            end
        end
        @(negedge clk);
        n_cmp++;
        if (a_if.load_done !== 1'b1 || a_if.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL load_done_timing: got done=%b we=%b, want done=1 we=0",
                     a_if.load_done, a_if.mem_we);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_if.load_done, a_if.fetch_gnt, a_if.draw_gnt, a_if.fetch_rvalid,
             a_if.draw_rvalid, a_if.mem_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {a_if.load_done, a_if.fetch_gnt, a_if.draw_gnt, a_if.fetch_rvalid,
                      a_if.draw_rvalid, a_if.mem_we});
        end
        n_cmp++;
        if (a_if.mem_waddr !== 12'h0 || a_if.mem_d !== 8'h0 || a_if.mem_raddr !== 12'h0) begin
            n_err++;
            $display("FAIL reset_buses: got waddr=%h d=%h raddr=%h, want 000 00 000",
                     a_if.mem_waddr, a_if.mem_d, a_if.mem_raddr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        a_if.fetch_req = 1'b1;
        a_if.draw_req  = 1'b1;
        #1;
        n_cmp++;
        if (a_if.fetch_gnt !== 1'b0 || a_if.draw_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_grant: got fgnt=%b dgnt=%b, want 0 0",
                     a_if.fetch_gnt, a_if.draw_gnt);
        end
        @(negedge clk);
        a_if.fetch_req = 1'b0;
        a_if.draw_req  = 1'b0;
    endtask

    task automatic test_load_contiguous();
        load_image(1'b1, 0);
    endtask

    task automatic test_solo_read();
        a_if.draw_req  = 1'b1;
        a_if.draw_addr = 12'h2A5;
        #1;
        n_cmp++;
        if (a_if.draw_gnt !== 1'b1 || a_if.fetch_gnt !== 1'b0 || a_if.mem_raddr !== 12'h2A5) begin
            n_err++;
            $display("FAIL solo_draw_gnt: got dgnt=%b fgnt=%b raddr=%h, want 1 0 2a5",
                     a_if.draw_gnt, a_if.fetch_gnt, a_if.mem_raddr);
        end
        @(negedge clk);
        a_if.draw_req = 1'b0;
        n_cmp++;
        if (a_if.draw_rvalid !== 1'b1 || a_if.rdata !== exp_mem[12'h2A5]) begin
            n_err++;
            $display("FAIL solo_draw_data: got rvalid=%b rdata=%h, want 1 %h",
                     a_if.draw_rvalid, a_if.rdata, exp_mem[12'h2A5]);
        end
        a_if.fetch_req  = 1'b1;
        a_if.fetch_addr = 12'h200;
        #1;
        n_cmp++;
        if (a_if.fetch_gnt !== 1'b1 || a_if.draw_gnt !== 1'b0 || a_if.mem_raddr !== 12'h200) begin
            n_err++;
            $display("FAIL solo_fetch_gnt: got fgnt=%b dgnt=%b raddr=%h, want 1 0 200",
                     a_if.fetch_gnt, a_if.draw_gnt, a_if.mem_raddr);
        end
        @(negedge clk);
        a_if.fetch_req = 1'b0;
        #1;
        n_cmp++;
        if (a_if.fetch_rvalid !== 1'b1 || a_if.draw_rvalid !== 1'b0 ||
            a_if.rdata !== exp_mem[12'h200]) begin
            n_err++;
            $display("FAIL solo_fetch_data: got frv=%b drv=%b rdata=%h, want 1 0 %h",
                     a_if.fetch_rvalid, a_if.draw_rvalid, a_if.rdata, exp_mem[12'h200]);
        end
        n_cmp++;
        if (a_if.mem_raddr !== 12'h200) begin
            n_err++;
            $display("FAIL solo_raddr_hold: got %h, want 200", a_if.mem_raddr);
        end
        @(negedge clk);
        n_cmp++;
        if (a_if.fetch_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL solo_rvalid_pulse: got %b, want 0", a_if.fetch_rvalid);
        end
    endtask

    // Last solo winner was fetch, so a sustained tie goes draw, fetch, draw, ...
    task automatic test_contention();
        bit          prev_f = 1'b0;
        bit          prev_d = 1'b0;
        bit          want_d;
        logic [11:0] prev_a = '0;
        a_if.fetch_addr = 12'h210;
        a_if.draw_addr  = 12'h2F0;
        for (int k = 0; k < 7; k++) begin
            a_if.fetch_req = (k < 6);
            a_if.draw_req  = (k < 6);
            #1;
            n_cmp++;
            if ({a_if.fetch_rvalid, a_if.draw_rvalid} !== {prev_f, prev_d} ||
                ((prev_f || prev_d) && a_if.rdata !== exp_mem[prev_a])) begin
                n_err++;
                $display("FAIL contention_rvalid[%0d]: got frv=%b drv=%b rdata=%h, want %b %b %h",
                         k, a_if.fetch_rvalid, a_if.draw_rvalid, a_if.rdata,
                         prev_f, prev_d, exp_mem[prev_a]);
            end
            if (k < 6) begin
                want_d = (k % 2 == 0);
                n_cmp++;
                if (a_if.fetch_gnt !== !want_d || a_if.draw_gnt !== want_d) begin
                    n_err++;
                    $display("FAIL contention_gnt[%0d]: got fgnt=%b dgnt=%b, want %b %b",
                             k, a_if.fetch_gnt, a_if.draw_gnt, !want_d, want_d);
                end
                prev_f = !want_d;
                prev_d = want_d;
                prev_a = want_d ? 12'h2F0 : 12'h210;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_reads();
        bit          f_pend = 1'b0;
        bit          d_pend = 1'b0;
        bit          pf = 1'b0;
        bit          pd = 1'b0;
        bit          last_was_draw = 1'b0;
        bit          gf;
        bit          gd;
        logic [11:0] fa = 12'h210;
        logic [11:0] da = 12'h2F0;
        logic [11:0] held = 12'h210;
        logic [11:0] paddr = 12'h210;
        for (int c = 0; c <= 200; c++) begin
            if (c < 200) begin
                if (!f_pend && $urandom_range(1, 0) == 1) begin
                    f_pend = 1'b1;
                    fa     = 12'h200 + 12'($urandom_range(255, 0));
                end
                if (!d_pend && $urandom_range(1, 0) == 1) begin
                    d_pend = 1'b1;
                    da     = 12'h200 + 12'($urandom_range(255, 0));
                end
            end
            a_if.fetch_req  = f_pend;
            a_if.fetch_addr = fa;
            a_if.draw_req   = d_pend;
            a_if.draw_addr  = da;
            #1;
            n_cmp++;
            if ({a_if.fetch_rvalid, a_if.draw_rvalid} !== {pf, pd} ||
                ((pf || pd) && a_if.rdata !== exp_mem[paddr])) begin
                n_err++;
                $display("FAIL rand_read[%0d]: got frv=%b drv=%b rdata=%h, want %b %b %h",
                         c, a_if.fetch_rvalid, a_if.draw_rvalid, a_if.rdata, pf, pd, exp_mem[paddr]);
            end
            gf = 1'b0;
            gd = 1'b0;
            if (f_pend && d_pend) begin
                if (last_was_draw) gf = 1'b1;
                else gd = 1'b1;
            end else if (f_pend) begin
                gf = 1'b1;
            end else if (d_pend) begin
                gd = 1'b1;
            end
            if (gf) held = fa;
            else if (gd) held = da;
            n_cmp++;
            if (a_if.fetch_gnt !== gf || a_if.draw_gnt !== gd || a_if.mem_raddr !== held) begin
                n_err++;
                $display("FAIL rand_gnt[%0d]: got fgnt=%b dgnt=%b raddr=%h, want %b %b %h",
                         c, a_if.fetch_gnt, a_if.draw_gnt, a_if.mem_raddr, gf, gd, held);
            end
            if (gf || gd) last_was_draw = gd;
            pf    = gf;
            pd    = gd;
            paddr = held;
            if (gf) f_pend = 1'b0;
            if (gd) d_pend = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reload();
        logic [11:0] addr = 12'h2C3;
        logic [7:0]  old_q;
        old_q           = exp_mem[addr];
        a_if.fetch_req  = 1'b1;
        a_if.fetch_addr = addr;
        a_if.reload     = 1'b1;
        a_if.rx_i_v     = 1'b1;
        a_if.rx_i       = 8'h55;
        #1;
        n_cmp++;
        if (a_if.fetch_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL reload_same_cycle_gnt: got %b, want 1", a_if.fetch_gnt);
        end
        @(negedge clk);
        a_if.reload = 1'b0;
        a_if.rx_i_v = 1'b0;
        n_cmp++;
        if (a_if.fetch_rvalid !== 1'b1 || a_if.rdata !== old_q) begin
            n_err++;
            $display("FAIL reload_rvalid: got rvalid=%b rdata=%h, want 1 %h",
                     a_if.fetch_rvalid, a_if.rdata, old_q);
        end
        n_cmp++;
        if (a_if.load_done !== 1'b0 || a_if.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL reload_drop: got done=%b we=%b, want 0 0", a_if.load_done, a_if.mem_we);
        end
        load_image(1'b0, 3);
        n_cmp++;
        if (a_if.fetch_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL reload_regrant: got %b, want 1", a_if.fetch_gnt);
        end
        @(negedge clk);
        a_if.fetch_req = 1'b0;
        n_cmp++;
        if (a_if.fetch_rvalid !== 1'b1 || a_if.rdata !== exp_mem[addr]) begin
            n_err++;
            $display("FAIL reload_new_data: got rvalid=%b rdata=%h, want 1 %h",
                     a_if.fetch_rvalid, a_if.rdata, exp_mem[addr]);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_if.rx_i   = 8'(i);
            a_if.rx_i_v = 1'b1;
            @(negedge clk);
        end
        a_if.rx_i_v = 1'b0;
        rst_n       = 1'b0;
        #1;
        n_cmp++;
        if (a_if.mem_we !== 1'b0 || a_if.mem_waddr !== 12'h0 || a_if.mem_d !== 8'h0) begin
            n_err++;
            $display("FAIL areset_write_cancel: got we=%b addr=%h d=%h, want 0 000 00",
                     a_if.mem_we, a_if.mem_waddr, a_if.mem_d);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        a_if.rx_i   = 8'hA5;
        a_if.rx_i_v = 1'b1;
        @(negedge clk);
        a_if.rx_i_v = 1'b0;
        n_cmp++;
        if (a_if.mem_we !== 1'b1 || a_if.mem_waddr !== 12'h200 || a_if.mem_d !== 8'hA5) begin
            n_err++;
            $display("FAIL areset_first_byte: got we=%b addr=%h d=%h, want 1 200 a5",
                     a_if.mem_we, a_if.mem_waddr, a_if.mem_d);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        load_image(1'b0, 0);
        a_if.fetch_req  = 1'b1;
        a_if.fetch_addr = 12'h234;
        #1;
        n_cmp++;
        if (a_if.fetch_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL areset_pre_gnt: got %b, want 1", a_if.fetch_gnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({a_if.fetch_rvalid, a_if.draw_rvalid, a_if.load_done, a_if.fetch_gnt} !== 4'b0 ||
            a_if.mem_raddr !== 12'h0) begin
            n_err++;
            $display("FAIL areset_rvalid_cancel: got frv=%b drv=%b done=%b fgnt=%b raddr=%h, want 0 0 0 0 000",
                     a_if.fetch_rvalid, a_if.draw_rvalid, a_if.load_done, a_if.fetch_gnt, a_if.mem_raddr);
        end
        @(negedge clk);
        a_if.fetch_req = 1'b0;
        n_cmp++;
        if (a_if.fetch_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_rvalid_stays: got %b, want 0", a_if.fetch_rvalid);
        end
        rst_n = 1'b1;
    endtask

    // Instance B: base 0xFFE, four bytes with random gaps, wrapping to 0x000.
    task automatic test_load_wrap();
        int          sent = 0;
        int          gap  = 0;
        bit          pv   = 1'b0;
        logic [11:0] pa   = '0;
        logic [7:0]  pd   = '0;
        while (1) begin
            @(negedge clk);
            n_cmp++;
            if (b_if.mem_we !== pv || (pv && (b_if.mem_waddr !== pa || b_if.mem_d !== pd))) begin
                n_err++;
                $display("FAIL wrap_write: got we=%b addr=%h d=%h, want we=%b addr=%h d=%h",
                         b_if.mem_we, b_if.mem_waddr, b_if.mem_d, pv, pa, pd);
            end
            b_if.rx_i_v = 1'b0;
            if (sent == 4) break;
            if (gap > 0) begin
                gap--;
                pv = 1'b0;
            end else begin
                pd          = 8'($urandom);
                b_if.rx_i   = pd;
                b_if.rx_i_v = 1'b1;
                pv          = 1'b1;
                pa          = 12'hFFE + 12'(sent);
                sent++;
                gap = int'($urandom_range(3, 1));
            end
        end
        n_cmp++;
        if (b_if.load_done !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_done_early: got %b, want 0", b_if.load_done);
        end
        @(negedge clk);
        n_cmp++;
        if (b_if.load_done !== 1'b1 || b_if.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_done: got done=%b we=%b, want 1 0", b_if.load_done, b_if.mem_we);
        end
        b_if.rx_i   = 8'h77;
        b_if.rx_i_v = 1'b1;
        @(negedge clk);
        b_if.rx_i_v = 1'b0;
        n_cmp++;
        if (b_if.mem_we !== 1'b0) begin
            n_err++;
            $display("FAIL run_rx_ignored: got we=%b, want 0", b_if.mem_we);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        a_if.rx_i = '0;  a_if.rx_i_v = 1'b0; a_if.reload = 1'b0;
        a_if.fetch_req = 1'b0; a_if.fetch_addr = '0;
        a_if.draw_req  = 1'b0; a_if.draw_addr  = '0;
        b_if.rx_i = '0;  b_if.rx_i_v = 1'b0; b_if.reload = 1'b0;
        b_if.fetch_req = 1'b0; b_if.fetch_addr = '0;
        b_if.draw_req  = 1'b0; b_if.draw_addr  = '0;
        b_if.mem_q = '0;

        test_reset();
        test_load_contiguous();
        test_solo_read();
        test_contention();
        test_random_reads();
        test_reload();
        test_async_reset();
        test_load_wrap();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
